// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// opcode classification.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] OP_SHL   = 4'b0010;
    localparam logic [OP_W-1:0] OP_ASR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b0111;
    localparam logic [OP_W-1:0] OP_NEG   = 4'b1000;
    localparam logic [OP_W-1:0] OP_INC   = 4'b1001;
    localparam logic [OP_W-1:0] OP_DEC   = 4'b1010;
    localparam logic [OP_W-1:0] OP_PASSA = 4'b1011;
    localparam logic [OP_W-1:0] OP_PASSB = 4'b1100;
    localparam logic [OP_W-1:0] OP_MOVB  = 4'b1101;
    localparam logic [OP_W-1:0] OP_MOVA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_LOADA = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Register moves only update ALU internal registers; they produce no result.
    function automatic logic is_reg_op(input logic [OP_W-1:0] op);
        return (op == OP_MOVB) || (op == OP_MOVA) || (op == OP_LOADA);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Small synchronous command FIFO with combinational head read so the
// sequencer can pop and latch a command in the same clock.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command initiator for the operator-mux ALU: buffers {op, operand} commands,
// strobes them into the ALU one at a time and returns captured results.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_op,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic [3:0]                    alu_selector,
    output logic [DATA_W-1:0]             alu_data_in,
    output logic                          alu_enable,
    input  logic [DATA_W-1:0]             alu_y,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [3:0]                    res_op,
    output logic [DATA_W-1:0]             res_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CMD_W = OP_W + DATA_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t            state_reg;
    logic [CNT_W-1:0]  settle_cnt_reg;
    logic [CMD_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    // The head is consumed on the same edge that latches it onto the ALU bus.
    assign pop       = (state_reg == ST_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            alu_selector   <= '0;
            alu_data_in    <= '0;
            alu_enable     <= 1'b0;
            res_valid      <= 1'b0;
            res_op         <= '0;
            res_data       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_selector <= head[CMD_W-1:DATA_W];
                        alu_data_in  <= head[DATA_W-1:0];
                        alu_enable   <= 1'b1;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_enable     <= 1'b0;
                    settle_cnt_reg <= CNT_W'(SETTLE_CYCLES - 1);
                    state_reg      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // selector/data_in are left untouched so Y stays valid while settling.
                    if (settle_cnt_reg == '0) begin
                        if (is_reg_op(alu_selector)) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            res_data  <= alu_y;
                            res_op    <= alu_selector;
                            res_valid <= 1'b1;
                            state_reg <= ST_HOLD;
                        end
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU plus a command-level reference
// model that predicts the ordered result stream.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int FIFO_DEPTH    = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int DATA_W        = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic [3:0] alu_selector;
    logic [7:0] alu_data_in;
    logic       alu_enable;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_op;
    logic [7:0] res_data;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .DATA_W        (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .alu_selector (alu_selector),
        .alu_data_in  (alu_data_in),
        .alu_enable   (alu_enable),
        .alu_y        (alu_y),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_op       (res_op),
        .res_data     (res_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    // Behaviour of the ALU: Y is a pure function of the selector and registers A/B.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return 8'(a + b);
            4'd1:    return 8'(a - b);
            4'd2:    return 8'(a + a);
            4'd3:    return 8'($signed(a) >>> 1);
            4'd4:    return a | b;
            4'd5:    return a & b;
            4'd6:    return a ^ b;
            4'd7:    return ~a;
            4'd8:    return 8'(8'd0 - a);
            4'd9:    return 8'(a + 8'd1);
            4'd10:   return 8'(a - 8'd1);
            4'd11:   return a;
            4'd12:   return b;
            default: return a;
        endcase
    endfunction

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    assign alu_y = alu_fn(alu_selector, alu_a, alu_b);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (alu_enable) begin
            case (alu_selector)
                4'hF:    alu_a <= alu_data_in;
                4'hD:    alu_b <= alu_a;
                4'hE:    alu_a <= alu_b;
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
    } res_t;

    // Reference model: commands execute strictly in push order.
    logic [7:0] ref_a = '0;
    logic [7:0] ref_b = '0;
    res_t exp_q[$];
    res_t got_q[$];
    int   en_cyc[$];
    int   rise_cyc[$];
    int   cyc = 0;
    int   consec = 0;
    logic prev_en = 1'b0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (alu_enable) en_cyc.push_back(cyc);
        if (alu_enable && prev_en) consec++;
        if (res_valid && !prev_rv) rise_cyc.push_back(cyc);
        if (res_valid && res_ready) got_q.push_back({res_op, res_data});
        prev_en = alu_enable;
        prev_rv = res_valid;
    end

    task automatic ref_apply(input logic [3:0] op, input logic [7:0] data);
        case (op)
            4'hF:    ref_a = data;
            4'hD:    ref_b = ref_a;
            4'hE:    ref_a = ref_b;
            default: exp_q.push_back({op, alu_fn(op, ref_a, ref_b)});
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        en_cyc.delete();
        rise_cyc.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] data);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout op=%0h cmd_ready=0 required acceptance within 200 clks", op);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ref_apply(op, data);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || res_valid) begin
            checks++; failures++;
            $display("FAIL idle_timeout busy=%0b res_valid=%0b required idle within 500 clks", busy, res_valid);
        end
        tick();
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checks++; failures++;
            $display("FAIL res_valid_timeout res_valid=0 required 1 within 100 clks");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (alu_enable !== 1'b0) begin failures++; $display("FAIL reset_alu_enable got=%0b exp=0", alu_enable); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++;
        if ({res_op, res_data, alu_selector, alu_data_in} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got res_op=%0h res_data=%0h sel=%0h din=%0h exp all 0",
                     res_op, res_data, alu_selector, alu_data_in);
        end
        tick();
    endtask

    task automatic test_load_add();
        int diff;
        clear_obs();
        res_ready = 1'b1;
        push_cmd(OP_LOADA, 8'd5);
        push_cmd(OP_SHL, 8'($urandom));
        wait_idle();
        checks++; if (en_cyc.size() !== 2) begin failures++; $display("FAIL load_add_enables got=%0d exp=2", en_cyc.size()); end
        checks++; if (rise_cyc.size() !== 1) begin failures++; $display("FAIL load_add_results got=%0d exp=1", rise_cyc.size()); end
        diff = (en_cyc.size() > 1 && rise_cyc.size() > 0) ? rise_cyc[0] - en_cyc[1] : -1;
        checks++; if (diff !== SETTLE_CYCLES + 1) begin failures++; $display("FAIL load_add_latency got=%0d exp=%0d", diff, SETTLE_CYCLES + 1); end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {OP_SHL, 8'd10}) begin
            failures++;
            $display("FAIL load_add_result got_n=%0d first=%0h exp op=2 data=0a", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 12'hxxx);
        end
    endtask

    task automatic test_fifo_full();
        int n;
        clear_obs();
        res_ready = 1'b0;
        push_cmd(4'($urandom_range(0, 12)), 8'($urandom));
        wait_res_valid();
        tick();
        for (int i = 0; i < 4; i++) push_cmd(4'($urandom_range(0, 12)), 8'($urandom));
        cmd_op    = 4'($urandom_range(0, 12));
        cmd_data  = 8'($urandom);
        cmd_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_cmd_ready got=%0b exp=0", cmd_ready); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL full_accept_after_drain cmd_ready=0 required 1 within 20 clks");
            cmd_valid = 1'b0;
        end else begin
            tick();
            cmd_valid = 1'b0;
            ref_apply(cmd_op, cmd_data);
            @(negedge clk);
            checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count_refill got=%0d exp=4", fifo_count); end
            tick();
        end
        res_ready = 1'b1;
        wait_idle();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL full_result_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_result[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hold();
        clear_obs();
        res_ready = 1'b0;
        push_cmd(OP_LOADA, 8'd2);
        push_cmd(OP_MOVB, 8'($urandom));
        push_cmd(OP_LOADA, 8'hFD);
        push_cmd(OP_OR, 8'($urandom));
        wait_res_valid();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_op !== OP_OR || res_data !== 8'hFF) begin
                failures++;
                $display("FAIL hold_stable[%0d] got valid=%0b op=%0h data=%0h exp valid=1 op=4 data=ff",
                         i, res_valid, res_op, res_data);
            end
            @(negedge clk);
        end
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%0b exp=0", res_valid); end
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL hold_result got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
        res_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_simul_push_pop();
        clear_obs();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(4'($urandom_range(0, 12)), 8'($urandom));
        wait_res_valid();
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_pre_count got=%0d exp=2", fifo_count); end
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        cmd_op    = 4'($urandom_range(0, 12));
        cmd_data  = 8'($urandom);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ref_apply(cmd_op, cmd_data);
        @(negedge clk);
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", fifo_count); end
        checks++; if (alu_enable !== 1'b1) begin failures++; $display("FAIL simul_pop_enable got=%0b exp=1", alu_enable); end
        res_ready = 1'b1;
        wait_idle();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL simul_result_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL simul_result[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        fork
            begin
                for (int i = 0; i < 16; i++) push_cmd(4'($urandom_range(0, 15)), 8'($urandom));
            end
            begin
                repeat (200) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                res_ready = 1'b1;
            end
        join
        wait_idle();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL b2b_final_count got=%0d exp=0", fifo_count); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_result_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_result[%0d] got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int en_before;
        clear_obs();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(4'($urandom_range(0, 12)), 8'($urandom));
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=3", fifo_count); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (alu_enable !== 1'b0) begin failures++; $display("FAIL rstmid_enable got=%0b exp=0", alu_enable); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_flags got busy=%0b cmd_ready=%0b exp busy=0 cmd_ready=1", busy, cmd_ready); end
        #1;
        reset = 1'b0;
        ref_a = '0;
        ref_b = '0;
        exp_q.delete();
        en_before = en_cyc.size();
        repeat (20) tick();
        checks++; if (en_cyc.size() !== en_before) begin failures++; $display("FAIL rstmid_no_enable got=%0d exp=%0d", en_cyc.size(), en_before); end
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_no_result got=%0d exp=0", got_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_add();
        test_fifo_full();
        test_hold();
        test_simul_push_pop();
        test_back_to_back();
        test_reset_mid();
        checks++; if (consec !== 0) begin failures++; $display("FAIL enable_consecutive got=%0d exp=0", consec); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
